pwm_bank: RTL and testbench



---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_bank_if.sv | 33 +++
 rtl/pwm_channel.sv | 46 ++++
 rtl/pwm_bank.sv | 75 +++++++
 tb/tb_pwm_bank.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the eight-channel PWM bank.
package pwm_pkg;

    localparam int PWM_CHANNELS = 8;
    localparam int PWM_WIDTH    = 16;

    typedef logic [PWM_WIDTH-1:0] duty_t;

endpackage

// File: rtl/pwm_bank_if.sv
// Register-file side of the PWM bank: enable, eight duty words, PWM outputs
// and the period_start pulse.
interface pwm_bank_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
);

    logic                    en;
    logic [WIDTH-1:0]        pwm_reg0;
    logic [WIDTH-1:0]        pwm_reg1;
    logic [WIDTH-1:0]        pwm_reg2;
    logic [WIDTH-1:0]        pwm_reg3;
    logic [WIDTH-1:0]        pwm_reg4;
    logic [WIDTH-1:0]        pwm_reg5;
    logic [WIDTH-1:0]        pwm_reg6;
    logic [WIDTH-1:0]        pwm_reg7;
    logic [PWM_CHANNELS-1:0] pwm_out;
    logic                    period_start;

    modport master (
        output en, pwm_reg0, pwm_reg1, pwm_reg2, pwm_reg3,
               pwm_reg4, pwm_reg5, pwm_reg6, pwm_reg7,
        input  pwm_out, period_start
    );

    modport slave (
        input  en, pwm_reg0, pwm_reg1, pwm_reg2, pwm_reg3,
               pwm_reg4, pwm_reg5, pwm_reg6, pwm_reg7,
        output pwm_out, period_start
    );

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: optional duty shadow register, comparator and output flop.
// Build with PWM_BANK_SHADOW_EN defined to latch duties only on period wraps.
module pwm_channel #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    input  logic             wrap,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty_in,
    output logic             pwm_out
);

    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] duty_next;

    assign cnt_next = wrap ? '0 : cnt + 1'b1;

`ifdef PWM_BANK_SHADOW_EN
    logic [WIDTH-1:0] duty_sh;

    always_ff @(posedge clk) begin
        if (rst)
            duty_sh <= '0;
        else if (wrap)
            duty_sh <= duty_in;
    end

    // The compare on a wrap must already see the freshly loaded duty.
    assign duty_next = wrap ? duty_in : duty_sh;
`else
    assign duty_next = duty_in;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            pwm_out <= 1'b0;
        else if (!en)
            pwm_out <= 1'b0;
        else if (tick)
            pwm_out <= (cnt_next < duty_next);
    end

endmodule

// File: rtl/pwm_bank.sv
// Eight-channel PWM bank: shared prescaler, period counter and wrap pulse,
// feeding eight pwm_channel instances. Shadowing controlled by PWM_BANK_SHADOW_EN.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic      clk,
    input  logic      rst,
    pwm_bank_if.slave bus
);

    localparam int DIVW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [DIVW-1:0]         div;
    logic [WIDTH-1:0]        cnt;
    logic                    tick;
    logic                    wrap;
    logic                    period_start_q;
    logic [PWM_CHANNELS-1:0] out_vec;
    logic [WIDTH-1:0]        duty_in [PWM_CHANNELS];

    assign duty_in[0] = bus.pwm_reg0;
    assign duty_in[1] = bus.pwm_reg1;
    assign duty_in[2] = bus.pwm_reg2;
    assign duty_in[3] = bus.pwm_reg3;
    assign duty_in[4] = bus.pwm_reg4;
    assign duty_in[5] = bus.pwm_reg5;
    assign duty_in[6] = bus.pwm_reg6;
    assign duty_in[7] = bus.pwm_reg7;

    assign tick = bus.en && (div == DIVW'(PRESCALE - 1));
    assign wrap = tick && (cnt == '1);

    // Parking cnt at all-ones makes the first tick after enable a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            div            <= '0;
            cnt            <= '1;
            period_start_q <= 1'b0;
        end else if (!bus.en) begin
            div            <= '0;
            cnt            <= '1;
            period_start_q <= 1'b0;
        end else begin
            period_start_q <= wrap;
            if (tick) begin
                div <= '0;
                cnt <= cnt + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    for (genvar n = 0; n < PWM_CHANNELS; n++) begin : g_ch
        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en),
            .tick    (tick),
            .wrap    (wrap),
            .cnt     (cnt),
            .duty_in (duty_in[n]),
            .pwm_out (out_vec[n])
        );
    end

    assign bus.pwm_out      = out_vec;
    assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: WIDTH=4 with PRESCALE=1 (bank A) and PRESCALE=3 (bank B).
module tb_pwm_bank;

    logic       clk;
    logic       rst;
    logic       enA;
    logic       enB;
    logic [3:0] regs [8];

    int checks = 0;
    int errors = 0;

    int         k;
    logic [3:0] sh [8];
    logic [7:0] expOut;
    logic       expPs;

    pwm_bank_if #(.WIDTH(4)) busA ();
    pwm_bank_if #(.WIDTH(4)) busB ();

    assign busA.en       = enA;
    assign busA.pwm_reg0 = regs[0];
    assign busA.pwm_reg1 = regs[1];
    assign busA.pwm_reg2 = regs[2];
    assign busA.pwm_reg3 = regs[3];
    assign busA.pwm_reg4 = regs[4];
    assign busA.pwm_reg5 = regs[5];
    assign busA.pwm_reg6 = regs[6];
    assign busA.pwm_reg7 = regs[7];

    assign busB.en       = enB;
    assign busB.pwm_reg0 = 4'd4;
    assign busB.pwm_reg1 = 4'd0;
    assign busB.pwm_reg2 = 4'd0;
    assign busB.pwm_reg3 = 4'd0;
    assign busB.pwm_reg4 = 4'd0;
    assign busB.pwm_reg5 = 4'd0;
    assign busB.pwm_reg6 = 4'd0;
    assign busB.pwm_reg7 = 4'd0;

    pwm_bank #(.WIDTH(4), .PRESCALE(1)) u_dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    pwm_bank #(.WIDTH(4), .PRESCALE(3)) u_dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock on both banks; bank A is compared against a reference model every edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (rst) begin
            k      = 15;
            expOut = '0;
            expPs  = 1'b0;
            for (int n = 0; n < 8; n++) sh[n] = '0;
        end else if (!enA) begin
            k      = 15;
            expOut = '0;
            expPs  = 1'b0;
        end else begin
            k = (k + 1) % 16;
            if (k == 0)
                for (int n = 0; n < 8; n++) sh[n] = regs[n];
            expPs = (k == 0);
            for (int n = 0; n < 8; n++) begin
`ifdef PWM_BANK_SHADOW_EN
                expOut[n] = (k < int'(sh[n]));
`else
                expOut[n] = (k < int'(regs[n]));
`endif
            end
        end
        checkOutput("A.pwm_out", 32'(busA.pwm_out), 32'(expOut));
        checkOutput("A.period_start", 32'(busA.period_start), 32'(expPs));
    endtask

    task automatic runUntilK(input int target, input string tag);
        int n;
        n = 0;
        while (k != target && n < 40) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(k), 32'(target));
    endtask

    initial begin
        int sum0, sum1, sum2, sum3, sum4;
        int highsB;
        int psIdx [$];

        k   = 15;
        rst = 1'b1;
        enA = 1'b0;
        enB = 1'b0;
        regs[0] = 4'd4;  regs[1] = 4'd0;  regs[2] = 4'd15; regs[3] = 4'd4;
        regs[4] = 4'd8;  regs[5] = 4'd1;  regs[6] = 4'd2;  regs[7] = 4'd3;

        applyStimulus();
        applyStimulus();
        checkOutput("reset_out", 32'(busA.pwm_out), 32'h0);
        checkOutput("reset_psB", 32'(busB.period_start), 32'h0);
        rst = 1'b0;
        applyStimulus();
        checkOutput("idle_out", 32'(busA.pwm_out), 32'h0);

        // Enable: wrap on the very next edge, then a 16-clock period.
        enA = 1'b1;
        sum0 = 0; sum1 = 0; sum2 = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            if (i == 0) checkOutput("first_ps", 32'(busA.period_start), 32'h1);
            if (i == 15) checkOutput("out2_low_k15", 32'(busA.pwm_out[2]), 32'h0);
            sum0 += int'(busA.pwm_out[0]);
            sum1 += int'(busA.pwm_out[1]);
            sum2 += int'(busA.pwm_out[2]);
        end
        checkOutput("out0_high4", 32'(sum0), 32'd4);
        checkOutput("out1_never", 32'(sum1), 32'd0);
        checkOutput("out2_high15", 32'(sum2), 32'd15);
        applyStimulus();
        checkOutput("ps_period16", 32'(busA.period_start), 32'h1);

        // Duty change mid-period on channel 3.
        runUntilK(6, "reach_k6");
        regs[3] = 4'd10;
        sum3 = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus();
            sum3 += int'(busA.pwm_out[3]);
        end
`ifdef PWM_BANK_SHADOW_EN
        checkOutput("out3_rest_old", 32'(sum3), 32'd0);
`else
        checkOutput("out3_rest_new", 32'(sum3), 32'd3);
`endif
        sum3 = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            sum3 += int'(busA.pwm_out[3]);
        end
        checkOutput("out3_high10", 32'(sum3), 32'd10);

        // Drop enable at cnt=2, hold low 5 clocks, re-enable.
        runUntilK(2, "reach_k2");
        enA = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            if (i == 0) checkOutput("en_drop_out", 32'(busA.pwm_out), 32'h0);
        end
        enA = 1'b1;
        sum4 = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            if (i == 0) checkOutput("reen_ps", 32'(busA.period_start), 32'h1);
            sum4 += int'(busA.pwm_out[4]);
        end
        checkOutput("out4_high8", 32'(sum4), 32'd8);

        // One-clock reset mid-period with enable still high.
        runUntilK(5, "reach_k5");
        rst = 1'b1;
        applyStimulus();
        checkOutput("rst_mid_out", 32'(busA.pwm_out), 32'h0);
        rst = 1'b0;
        applyStimulus();
        checkOutput("rst_wrap_ps", 32'(busA.period_start), 32'h1);
        checkOutput("rst_reload_out0", 32'(busA.pwm_out[0]), 32'h1);
        for (int i = 0; i < 20; i++) applyStimulus();

        // Bank B with PRESCALE=3: 48-clock period, 12 clocks high.
        enA = 1'b0;
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        enB = 1'b1;
        highsB = 0;
        for (int i = 1; i <= 100; i++) begin
            applyStimulus();
            if (busB.period_start) psIdx.push_back(i);
            if (i >= 3 && i <= 50) highsB += int'(busB.pwm_out[0]);
            if (i == 2) checkOutput("B_no_early_out", 32'(busB.pwm_out[0]), 32'h0);
        end
        checkOutput("B_ps_count", 32'(psIdx.size()), 32'd3);
        if (psIdx.size() == 3) begin
            checkOutput("B_first_ps", 32'(psIdx[0]), 32'd3);
            checkOutput("B_second_ps", 32'(psIdx[1]), 32'd51);
            checkOutput("B_third_ps", 32'(psIdx[2]), 32'd99);
        end
        checkOutput("B_out0_high12", 32'(highsB), 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
